cache_line_adaptor: RTL
=======================

Name: cache_line_adaptor

Overview:
- Memory-side neighbour of the 2-way cache datapath.
- Takes the datapath's 128-bit line transfers (12-bit line address, line write data, line read data) and turns each into a 4-beat, 32-bit burst on the physical memory port.
- Returns the assembled line plus a one-cycle completion pulse to the cache controller.
- Serves one line transfer at a time; no internal queueing.

Parameters:
ADDR_W, 12, line address width (tag + set bits from datapath)
LINE_W, 128, cache line width in bits
BEAT_W, 32, memory burst beat width; BEATS = LINE_W/BEAT_W = 4 (derived localparam, not overridable)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
line_addr  input  ADDR_W  line address from datapath memaddr mux
line_wdata  input  LINE_W  line to write back (datapath mem_wdata)
line_read  input  1  controller requests line fill
line_write  input  1  controller requests line write-back
line_rdata  output  LINE_W  assembled fill line (to datapath mem_rdata)
line_resp  output  1  one-cycle pulse: transfer complete
burst_addr  output  ADDR_W+4  byte address {latched line_addr, 4'b0}
burst_o  output  BEAT_W  write beat data
burst_i  input  BEAT_W  read beat data
burst_read  output  1  read burst in progress
burst_write  output  1  write burst in progress
burst_resp  input  1  memory accepted/returned current beat

Behaviour:
- Reset is asynchronous and active-high; all state clears immediately on rst, without waiting for clk.
- Reset values: state IDLE, beat counter 0, line_rdata 0, address/data latches 0, line_resp 0, burst_read 0, burst_write 0, burst_o 0, burst_addr 0.
- States: IDLE, READ, WRITE, DONE. All outputs are Moore, decoded from registers only; no comb path from line_* or burst_resp to outputs.
- IDLE: on the rising edge, line_write=1 latches line_addr and line_wdata and moves to WRITE.
  - Otherwise line_read=1 latches line_addr and moves to READ.
  - Both high: write wins; read is ignored (illegal from controller, no error output).
  - Counter cleared.
- Request inputs are ignored outside IDLE. Changes to line_addr or line_wdata mid-burst have no effect.
- READ: burst_read=1; burst_addr constant for the whole burst.
  - Each cycle with burst_resp=1: burst_i is written to line_rdata[32*cnt +: 32] (beat 0 = bits 31:0) and cnt increments.
  - On the 4th beat (cnt==3 && burst_resp), go to DONE.
  - burst_resp=0 cycles are wait states: nothing changes.
- WRITE: burst_write=1; burst_o = latched line[32*cnt +: 32].
  - cnt increments on burst_resp; on the 4th beat, go to DONE.
- DONE: line_resp=1 for exactly one cycle; burst_read=burst_write=0; next state IDLE unconditionally.
- A request still high in the first IDLE cycle after DONE is treated as a new request. The controller must drop it on line_resp.
- line_rdata holds its value until the next READ beat overwrites it. WRITE bursts never modify it. Partially filled lines remain visible during READ; they are valid only at line_resp.
- Latency with zero wait states:
  - Request sampled at edge 0.
  - Beats at cycles 1-4.
  - line_resp in cycle 5.
  - The next request can be accepted at edge 6.
  - Each wait cycle adds one.
- Counter is 2 bits and wraps 3→0 only on the DONE transition. burst_resp in IDLE or DONE is ignored.
- rst asserted mid-burst aborts immediately:
  - burst_read/write drop asynchronously.
  - No line_resp is produced.
  - Partial line_rdata is cleared to 0.

Test Plan:
- Reset then idle 10 cycles → all outputs 0, burst_read/write never assert, burst_resp pulses ignored.
- line_read, line_addr=12'hABC, memory returns 32'h11111111, 22222222, 33333333, 44444444 with burst_resp every cycle → burst_addr=16'hABC0, burst_read high cycles 1-4, line_resp in cycle 5, line_rdata=128'h44444444_33333333_22222222_11111111.
- line_write, addr=12'h005, line_wdata=128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, burst_resp with 2 wait cycles before each beat → burst_o sequence 89ABCDEF, 01234567, CAFEF00D, DEADBEEF, each held through its wait cycles; line_resp once; line_rdata unchanged.
- line_read and line_write asserted together → WRITE burst only; line_addr changed mid-burst → burst_addr stays at the latched value.
- rst asserted after beat 2 of a read → burst_read drops in the same cycle, no line_resp, line_rdata=0; a fresh read after reset completes normally.
- Back-to-back read then write, with the controller dropping the request on line_resp → exactly two bursts, IDLE→READ→DONE→IDLE→WRITE→DONE, one line_resp each.

Source files
------------

// File: rtl/cache_line_adaptor_if.sv
// Line-side and burst-side signal bundle for cache_line_adaptor.
//   slave  : adaptor view (takes line requests and burst returns, drives burst port and fill line)
//   master : environment view (cache controller/datapath plus physical memory)
// Line side : line_addr, line_wdata, line_read, line_write -> ; <- line_rdata, line_resp
// Burst side: burst_addr, burst_o, burst_read, burst_write <- ; -> burst_i, burst_resp
interface cache_line_adaptor_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned LINE_W = 128,
  parameter int unsigned BEAT_W = 32
);
  logic [ADDR_W-1:0]   line_addr;
  logic [LINE_W-1:0]   line_wdata;
  logic                line_read;
  logic                line_write;
  logic [LINE_W-1:0]   line_rdata;
  logic                line_resp;
  logic [ADDR_W+3:0]   burst_addr;
  logic [BEAT_W-1:0]   burst_o;
  logic [BEAT_W-1:0]   burst_i;
  logic                burst_read;
  logic                burst_write;
  logic                burst_resp;

  modport slave (
    input  line_addr, line_wdata, line_read, line_write, burst_i, burst_resp,
    output line_rdata, line_resp, burst_addr, burst_o, burst_read, burst_write
  );

  modport master (
    output line_addr, line_wdata, line_read, line_write, burst_i, burst_resp,
    input  line_rdata, line_resp, burst_addr, burst_o, burst_read, burst_write
  );
endinterface

// File: rtl/cache_line_adaptor.sv
// Converts one cache line transfer at a time into a BEATS-beat burst on the
// physical memory port and returns a one-cycle line_resp on completion.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : cache_line_adaptor_if.slave (line request/response + memory burst port)
// All outputs come straight from registers; nothing combinational from inputs.
module cache_line_adaptor #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned LINE_W = 128,
  parameter int unsigned BEAT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  cache_line_adaptor_if.slave    bus
);
  localparam int unsigned BEATS = LINE_W / BEAT_W;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                          state;
  logic [CNT_W-1:0]                cnt;
  logic [CNT_W-1:0]                cnt_inc;
  logic [ADDR_W-1:0]               addr_q;
  logic [BEATS-1:0][BEAT_W-1:0]    wdata_q;
  logic [BEATS-1:0][BEAT_W-1:0]    rdata_q;
  logic [BEAT_W-1:0]               bo_q;
  logic                            resp_q;
  logic                            rd_q;
  logic                            wr_q;

  assign cnt_inc = cnt + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      bo_q    <= '0;
      resp_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      resp_q <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          // Write has priority when both requests are raised together.
          if (bus.line_write) begin
            addr_q  <= bus.line_addr;
            wdata_q <= bus.line_wdata;
            bo_q    <= bus.line_wdata[BEAT_W-1:0];
            wr_q    <= 1'b1;
            state   <= WRITE;
          end else if (bus.line_read) begin
            addr_q <= bus.line_addr;
            rd_q   <= 1'b1;
            state  <= READ;
          end
        end
        READ: begin
          if (bus.burst_resp) begin
            rdata_q[cnt] <= bus.burst_i;
            cnt          <= cnt_inc;
            if (cnt == LAST) begin
              rd_q   <= 1'b0;
              resp_q <= 1'b1;
              state  <= DONE;
            end
          end
        end
        WRITE: begin
          if (bus.burst_resp) begin
            // Preload the next beat so burst_o stays a plain register.
            bo_q <= wdata_q[cnt_inc];
            cnt  <= cnt_inc;
            if (cnt == LAST) begin
              wr_q   <= 1'b0;
              resp_q <= 1'b1;
              state  <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.line_rdata  = rdata_q;
  assign bus.line_resp   = resp_q;
  assign bus.burst_addr  = {addr_q, 4'b0000};
  assign bus.burst_o     = bo_q;
  assign bus.burst_read  = rd_q;
  assign bus.burst_write = wr_q;
endmodule
